seg_scan_decoder: RTL and testbench



---
 rtl/seg_scan_decoder_pkg.sv | 42 ++++
 rtl/seg_pattern_decode.sv | 40 ++++
 rtl/seg_scan_decoder.sv | 183 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// rtl/seg_scan_decoder_pkg.sv - shared seven-segment table, bit order and FSM states
// One pattern table for the encoder and this decoder so both always agree.
package seg_scan_decoder_pkg;

  // Bit positions inside the 7-bit active-low segment bus
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A_PAT = 7'b0001000;
  localparam logic [6:0] SEG_B_PAT = 7'b1100000;
  localparam logic [6:0] SEG_C_PAT = 7'b0110001;
  localparam logic [6:0] SEG_D_PAT = 7'b1000010;
  localparam logic [6:0] SEG_E_PAT = 7'b0110000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef logic [1:0] scan_state_t;
  localparam scan_state_t IDLE   = 2'd0;
  localparam scan_state_t SETTLE = 2'd1;
  localparam scan_state_t LOCKED = 2'd2;

  typedef struct packed {
    logic [3:0] nibble;
    logic       err;
    logic       blank;
  } seg_decode_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - active-low segment pattern to hex nibble
// Exact inverse of the encoder table; anything else is flagged as an error.
module seg_pattern_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       err,
  output logic       blank
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    blank  = 1'b0;
    case (seg_n)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A_PAT: nibble = 4'hA;
      SEG_B_PAT: nibble = 4'hB;
      SEG_C_PAT: nibble = 4'hC;
      SEG_D_PAT: nibble = 4'hD;
      SEG_E_PAT: nibble = 4'hE;
      SEG_BLANK: begin
        nibble = 4'hF;
        blank  = 1'b1;
      end
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers per-position hex digits from a scanned display bus
// Synchronizes the bus, waits for a stable single-select sample, captures and ages digits.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int IDX_W          = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    update,
  output logic [IDX_W-1:0]        update_idx
);

  localparam int          RW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] TO_MAX = RW'(TIMEOUT_CYCLES);

  logic [NUM_DIGITS-1:0] an_s1, an_s2, an_prev;
  logic [6:0]            seg_s1, seg_s2, seg_prev;

  // Idle bus is all-ones, so the synchronizers reset to that rather than to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1    <= '1;
      an_s2    <= '1;
      an_prev  <= '1;
      seg_s1   <= '1;
      seg_s2   <= '1;
      seg_prev <= '1;
    end else begin
      an_s1    <= an_n;
      an_s2    <= an_s1;
      an_prev  <= an_s2;
      seg_s1   <= seg_n;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
    end
  end

  logic [NUM_DIGITS-1:0] sel;
  logic                  sel_valid;
  logic                  changed;

  assign sel       = ~an_s2;
  assign sel_valid = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
  assign changed   = (an_s2 != an_prev) || (seg_s2 != seg_prev);

  logic [3:0]  dec_nib;
  logic        dec_err;
  logic        dec_blank;
  seg_decode_t dec;

  seg_pattern_decode u_decode (
    .seg_n  (seg_s2),
    .nibble (dec_nib),
    .err    (dec_err),
    .blank  (dec_blank)
  );

  assign dec = {dec_nib, dec_err, dec_blank};

  logic [IDX_W-1:0] sel_idx;
  seg_decode_t      cur;
  logic             cur_valid;

  always_comb begin
    sel_idx   = '0;
    cur       = '0;
    cur_valid = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) begin
        sel_idx   = IDX_W'(i);
        cur       = {digits[4*i +: 4], digit_err[i], digit_blank[i]};
        cur_valid = digit_valid[i];
      end
    end
  end

  logic [7:0]  stab_cnt, stab_nxt;
  scan_state_t state, state_nxt;
  logic        capture;
  logic        value_new;

  always_comb begin
    if (changed || !sel_valid) begin
      stab_nxt = 8'd0;
    end else if (stab_cnt == STAB_MAX) begin
      stab_nxt = stab_cnt;
    end else begin
      stab_nxt = stab_cnt + 8'd1;
    end
  end

  // Capture on the edge where the count reaches its limit, i.e. the STABLE_CYCLES-th identical sample
  assign capture   = (state == SETTLE) && sel_valid && !changed && (stab_nxt == STAB_MAX);
  assign value_new = !cur_valid || (cur != dec);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sel_valid) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!sel_valid)   state_nxt = IDLE;
        else if (capture) state_nxt = LOCKED;
      end
      LOCKED: begin
        if (!sel_valid)   state_nxt = IDLE;
        else if (changed) state_nxt = SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      stab_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      stab_cnt <= stab_nxt;
    end
  end

  logic [RW-1:0] ref_cnt [NUM_DIGITS];

  // A capture and a timeout on the same edge resolve in favour of the capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_valid <= '0;
      digit_err   <= '0;
      digit_blank <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) ref_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && sel[i]) begin
          digits[4*i +: 4] <= dec_nib;
          digit_err[i]     <= dec_err;
          digit_blank[i]   <= dec_blank;
          digit_valid[i]   <= 1'b1;
          ref_cnt[i]       <= '0;
        end else if (ref_cnt[i] != TO_MAX) begin
          ref_cnt[i] <= ref_cnt[i] + RW'(1);
          if (ref_cnt[i] == TO_MAX - RW'(1)) begin
            digits[4*i +: 4] <= 4'h0;
            digit_err[i]     <= 1'b0;
            digit_blank[i]   <= 1'b0;
            digit_valid[i]   <= 1'b0;
          end
        end
      end
    end
  end

  logic             upd_pend;
  logic [IDX_W-1:0] idx_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_pend   <= 1'b0;
      idx_pend   <= '0;
      update     <= 1'b0;
      update_idx <= '0;
    end else begin
      upd_pend <= capture && value_new;
      idx_pend <= sel_idx;
      update   <= upd_pend;
      if (upd_pend) update_idx <= idx_pend;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;

  localparam int N = 4;
  localparam int S = 8;
  localparam int T = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] an_n;
  logic [6:0]   seg_n;
  logic [4*N-1:0] digits;
  logic [N-1:0] digit_valid, digit_err, digit_blank;
  logic         update;
  logic [1:0]   update_idx;

  seg_scan_decoder #(
    .NUM_DIGITS     (N),
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .digits      (digits),
    .digit_valid (digit_valid),
    .digit_err   (digit_err),
    .digit_blank (digit_blank),
    .update      (update),
    .update_idx  (update_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [1:0] exp_q [$];

  logic [6:0] pat [17] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b1111111,
                           7'b1111110};
  logic [3:0] nib [17] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                           4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    an_n  = '1;
    seg_n = '1;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && update === 1'b1) begin
      pulses++;
      if (exp_q.size() == 0) chk("unexpected_update", 32'(update), 0);
      else                   chk("update_idx", 32'(update_idx), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, fv, fu, c, n;
    logic [3:0] sel;

    // Reset with a noisy bus
    rst_n = 1'b0;
    an_n  = 4'($urandom);
    seg_n = 7'($urandom);
    #1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      an_n  = 4'($urandom);
      seg_n = 7'($urandom);
    end
    chk("rst_digits", 32'(digits), 0);
    chk("rst_valid", 32'(digit_valid), 0);
    chk("rst_err", 32'(digit_err), 0);
    chk("rst_blank", 32'(digit_blank), 0);
    chk("rst_update", 32'(update), 0);
    chk("rst_update_idx", 32'(update_idx), 0);
    an_n  = '1;
    seg_n = '1;
    rst_n = 1'b1;
    cyc(30);
    chk("idle_digits", 32'(digits), 0);
    chk("idle_valid", 32'(digit_valid), 0);

    // Basic capture latency on digit 0
    p0 = pulses;
    fv = -1;
    fu = -1;
    an_n  = 4'b1110;
    seg_n = 7'b0000110;
    exp_q.push_back(2'd0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (fv < 0 && digit_valid[0]) fv = k;
      if (fu < 0 && update) fu = k;
    end
    chk("basic_valid_cycle", 32'(fv), 10);
    chk("basic_update_cycle", 32'(fu), 11);
    chk("basic_digits", 32'(digits), 32'h0003);
    chk("basic_valid", 32'(digit_valid), 32'h1);
    chk("basic_pulses", 32'(pulses - p0), 1);
    chk("basic_update_idx", 32'(update_idx), 0);

    // Full table on digit 2, including blank and an unknown pattern
    an_n = 4'b1011;
    for (int k = 0; k < 17; k++) begin
      seg_n = pat[k];
      exp_q.push_back(2'd2);
      cyc(20);
      chk($sformatf("tbl%0d_nib", k), 32'(digits[11:8]), 32'(nib[k]));
      chk($sformatf("tbl%0d_err", k), 32'(digit_err[2]), (k == 16) ? 1 : 0);
      chk($sformatf("tbl%0d_blank", k), 32'(digit_blank[2]), (k == 15) ? 1 : 0);
      chk($sformatf("tbl%0d_valid", k), 32'(digit_valid[2]), 1);
    end
    chk("tbl_queue_drained", 32'(exp_q.size()), 0);

    // Glitch filter: one sample short of stable, then a double select
    do_reset();
    p0 = pulses;
    an_n  = 4'b1101;
    seg_n = pat[5];
    cyc(S - 1);
    an_n  = 4'b1100;
    seg_n = pat[6];
    cyc(50);
    an_n  = '1;
    seg_n = '1;
    cyc(5);
    chk("glitch_valid", 32'(digit_valid), 0);
    chk("glitch_digits", 32'(digits), 0);
    chk("glitch_pulses", 32'(pulses - p0), 0);

    // Scan loop "1234", period equal to the timeout
    do_reset();
    p0 = pulses;
    for (int r = 0; r < 10; r++) begin
      for (int d = 0; d < 4; d++) begin
        sel   = 4'b0001 << d;
        an_n  = ~sel;
        seg_n = pat[d + 1];
        if (r == 0) exp_q.push_back(2'(d));
        cyc(16);
      end
    end
    chk("scan_digits", 32'(digits), 32'h4321);
    chk("scan_valid", 32'(digit_valid), 32'hF);
    chk("scan_pulses", 32'(pulses - p0), 4);

    // Timeout of digit 1
    do_reset();
    an_n  = 4'b1101;
    seg_n = pat[7];
    exp_q.push_back(2'd1);
    c = 0;
    while (!digit_valid[1] && c < 40) begin
      cyc(1);
      c++;
    end
    chk("to_captured", 32'(digit_valid[1]), 1);
    chk("to_nib", 32'(digits[7:4]), 7);
    an_n  = '1;
    seg_n = '1;
    cyc(3);
    p0 = pulses;
    n = 3;
    while (digit_valid[1] && n < 200) begin
      cyc(1);
      n++;
    end
    chk("to_latency", 32'(n), 64);
    chk("to_digits", 32'(digits), 0);
    chk("to_pulses", 32'(pulses - p0), 0);

    // Reset asserted while settling clears everything and nothing is captured afterwards
    an_n  = 4'b1011;
    seg_n = pat[4];
    exp_q.push_back(2'd2);
    cyc(15);
    chk("mid_pre_valid", 32'(digit_valid), 32'h4);
    an_n  = 4'b1110;
    seg_n = pat[9];
    cyc(6);
    p0 = pulses;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_digits", 32'(digits), 0);
    chk("mid_rst_valid", 32'(digit_valid), 0);
    an_n  = '1;
    seg_n = '1;
    cyc(2);
    rst_n = 1'b1;
    cyc(30);
    chk("mid_post_valid", 32'(digit_valid), 0);
    chk("mid_post_pulses", 32'(pulses - p0), 0);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
